// File: rtl/sys_ctrl.sv
// sys_ctrl: command controller sitting between the UART RX/TX synchronizers
// and the register file / ALU. Parses command frames, issues register-file
// writes/reads and ALU launches, and streams responses back to the UART TX.

module sys_ctrl #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned FUN_WIDTH  = 4,
  parameter int unsigned ALU_WIDTH  = 16
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] RX_P_DATA,
  input  logic                  RX_D_VLD,
  input  logic [DATA_WIDTH-1:0] RdData,
  input  logic                  RdData_Valid,
  input  logic [ALU_WIDTH-1:0]  ALU_OUT,
  input  logic                  ALU_OUT_VLD,
  input  logic                  TX_Busy,
  output logic                  WrEn,
  output logic                  RdEn,
  output logic [ADDR_WIDTH-1:0] Address,
  output logic [DATA_WIDTH-1:0] WrData,
  output logic                  ALU_EN,
  output logic [FUN_WIDTH-1:0]  ALU_FUN,
  output logic                  CLK_GATE_EN,
  output logic [DATA_WIDTH-1:0] TX_P_DATA,
  output logic                  TX_D_VLD
);

  // Command opcodes (first byte of a frame)
  localparam logic [DATA_WIDTH-1:0] CMD_WR      = DATA_WIDTH'(8'hAA);
  localparam logic [DATA_WIDTH-1:0] CMD_RD      = DATA_WIDTH'(8'hBB);
  localparam logic [DATA_WIDTH-1:0] CMD_ALU_OP  = DATA_WIDTH'(8'hCC);
  localparam logic [DATA_WIDTH-1:0] CMD_ALU_NOP = DATA_WIDTH'(8'hDD);

  // Response bytes are sliced out of the capture buffer
  localparam int unsigned LO_MSB = DATA_WIDTH - 1;
  localparam int unsigned HI_LSB = DATA_WIDTH;
  localparam int unsigned HI_MSB = 2 * DATA_WIDTH - 1;

  typedef enum logic [3:0] {
    IDLE,
    WR_ADDR,
    WR_DATA,
    RD_ADDR,
    RD_WAIT,
    OPA,
    OPB,
    FUN,
    ALU_WAIT,
    TX_LO,
    TX_HI
  } state_t;

  // Per-byte transmit handshake: wait idle -> present byte -> wait accept done
  typedef enum logic [1:0] {
    TXP_WAIT,
    TXP_SEND,
    TXP_DONE
  } tx_phase_t;

  state_t                 state;
  tx_phase_t              tx_phase;
  logic [ALU_WIDTH-1:0]   tx_buf;
  logic                   tx_two;

  // Frame parser, strobe generation and response transmit sequencing
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state       <= IDLE;
      tx_phase    <= TXP_WAIT;
      tx_buf      <= '0;
      tx_two      <= 1'b0;
      WrEn        <= 1'b0;
      RdEn        <= 1'b0;
      Address     <= '0;
      WrData      <= '0;
      ALU_EN      <= 1'b0;
      ALU_FUN     <= '0;
      CLK_GATE_EN <= 1'b0;
      TX_P_DATA   <= '0;
      TX_D_VLD    <= 1'b0;
    end else begin
      // Strobes are single-cycle unless re-asserted below
      WrEn   <= 1'b0;
      RdEn   <= 1'b0;
      ALU_EN <= 1'b0;

      case (state)
        IDLE: begin
          if (RX_D_VLD) begin
            case (RX_P_DATA)
              CMD_WR:      state <= WR_ADDR;
              CMD_RD:      state <= RD_ADDR;
              CMD_ALU_OP:  state <= OPA;
              CMD_ALU_NOP: begin
                state       <= FUN;
                CLK_GATE_EN <= 1'b1;
              end
              default:     state <= IDLE;
            endcase
          end
        end

        WR_ADDR: begin
          if (RX_D_VLD) begin
            Address <= RX_P_DATA[ADDR_WIDTH-1:0];
            state   <= WR_DATA;
          end
        end

        WR_DATA: begin
          if (RX_D_VLD) begin
            WrEn   <= 1'b1;
            WrData <= RX_P_DATA;
            state  <= IDLE;
          end
        end

        RD_ADDR: begin
          if (RX_D_VLD) begin
            Address <= RX_P_DATA[ADDR_WIDTH-1:0];
            RdEn    <= 1'b1;
            state   <= RD_WAIT;
          end
        end

        RD_WAIT: begin
          if (RdData_Valid) begin
            tx_buf   <= ALU_WIDTH'(RdData);
            tx_two   <= 1'b0;
            tx_phase <= TXP_WAIT;
            state    <= TX_LO;
          end
        end

        OPA: begin
          if (RX_D_VLD) begin
            WrEn    <= 1'b1;
            Address <= '0;
            WrData  <= RX_P_DATA;
            state   <= OPB;
          end
        end

        OPB: begin
          if (RX_D_VLD) begin
            WrEn        <= 1'b1;
            Address     <= ADDR_WIDTH'(1);
            WrData      <= RX_P_DATA;
            CLK_GATE_EN <= 1'b1;
            state       <= FUN;
          end
        end

        FUN: begin
          if (RX_D_VLD) begin
            ALU_FUN <= RX_P_DATA[FUN_WIDTH-1:0];
            ALU_EN  <= 1'b1;
            state   <= ALU_WAIT;
          end
        end

        ALU_WAIT: begin
          if (ALU_OUT_VLD) begin
            tx_buf      <= ALU_OUT;
            tx_two      <= 1'b1;
            tx_phase    <= TXP_WAIT;
            CLK_GATE_EN <= 1'b0;
            state       <= TX_LO;
          end
        end

        TX_LO, TX_HI: begin
          case (tx_phase)
            TXP_WAIT: begin
              if (!TX_Busy) begin
                TX_P_DATA <= (state == TX_HI) ? tx_buf[HI_MSB:HI_LSB] : tx_buf[LO_MSB:0];
                TX_D_VLD  <= 1'b1;
                tx_phase  <= TXP_SEND;
              end
            end
            TXP_SEND: begin
              // Hold the request until the transmitter shows it has taken it
              if (TX_Busy) begin
                TX_D_VLD <= 1'b0;
                tx_phase <= TXP_DONE;
              end
            end
            TXP_DONE: begin
              if (!TX_Busy) begin
                tx_phase <= TXP_WAIT;
                state    <= (state == TX_LO && tx_two) ? TX_HI : IDLE;
              end
            end
            default: tx_phase <= TXP_WAIT;
          endcase
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sys_ctrl.sv
// tb_sys_ctrl: directed plus randomized frames against a frame-level model of
// the controller, with register-file, ALU and UART-TX responders.

module tb_sys_ctrl;

  logic        CLK = 1'b0;
  logic        RST;
  logic [7:0]  RX_P_DATA;
  logic        RX_D_VLD;
  logic [7:0]  RdData;
  logic        RdData_Valid;
  logic [15:0] ALU_OUT;
  logic        ALU_OUT_VLD;
  logic        TX_Busy;
  logic        WrEn;
  logic        RdEn;
  logic [3:0]  Address;
  logic [7:0]  WrData;
  logic        ALU_EN;
  logic [3:0]  ALU_FUN;
  logic        CLK_GATE_EN;
  logic [7:0]  TX_P_DATA;
  logic        TX_D_VLD;

  sys_ctrl dut (
    .CLK(CLK), .RST(RST),
    .RX_P_DATA(RX_P_DATA), .RX_D_VLD(RX_D_VLD),
    .RdData(RdData), .RdData_Valid(RdData_Valid),
    .ALU_OUT(ALU_OUT), .ALU_OUT_VLD(ALU_OUT_VLD),
    .TX_Busy(TX_Busy),
    .WrEn(WrEn), .RdEn(RdEn), .Address(Address), .WrData(WrData),
    .ALU_EN(ALU_EN), .ALU_FUN(ALU_FUN), .CLK_GATE_EN(CLK_GATE_EN),
    .TX_P_DATA(TX_P_DATA), .TX_D_VLD(TX_D_VLD)
  );

  always #5 CLK = ~CLK;

  int vectors = 0;
  int miscompares = 0;

  // Responder-side state (register file, ALU, UART)
  logic [7:0]  rf [16];
  int          wr_cnt = 0;
  int          rd_cnt = 0;
  int          alu_cnt = 0;
  int          alu_lat = 2;
  logic        alu_force = 1'b0;
  logic [15:0] alu_force_val = 16'h0;
  logic [7:0]  tx_q [$];

  // Frame-level expectation state
  logic [7:0]  ref_regs [16];
  int          exp_wr = 0;
  int          exp_rd = 0;
  int          exp_alu = 0;
  logic [7:0]  exp_tx_q [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] alu_fn(input logic [3:0] f, input logic [7:0] a, input logic [7:0] b);
    case (f)
      4'd0:    return 16'(a) + 16'(b);
      4'd1:    return 16'(a) - 16'(b);
      4'd2:    return 16'(a) * 16'(b);
      4'd3:    return (b == 8'h0) ? 16'h0 : 16'(a / b);
      4'd4:    return {8'h00, a & b};
      4'd5:    return {8'h00, a | b};
      default: return {a, b};
    endcase
  endfunction

  function automatic int rgap();
    return ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 3)) : 0;
  endfunction

  // Register file, ALU and UART transmitter models, sampled mid-cycle
  initial begin : responder
    logic       rd_pend;
    logic [3:0] rd_addr;
    logic       alu_pend;
    int         alu_left;
    logic [15:0] alu_res;
    int         busy_left;
    int         stall;
    logic       vld_prev;
    logic       holding;
    logic [7:0] held;
    rd_pend = 1'b0; rd_addr = 4'h0; alu_pend = 1'b0; alu_left = 0; alu_res = 16'h0;
    busy_left = 0; stall = 2; vld_prev = 1'b0; holding = 1'b0; held = 8'h0;
    RdData = 8'h0; RdData_Valid = 1'b0; ALU_OUT = 16'h0; ALU_OUT_VLD = 1'b0; TX_Busy = 1'b0;
    for (int i = 0; i < 16; i++) rf[i] = 8'h0;
    forever begin
      @(negedge CLK);
      RdData_Valid = 1'b0;
      ALU_OUT_VLD  = 1'b0;
      if (WrEn || RdEn) chk("wr_rd_exclusive", 32'(WrEn & RdEn), 32'd0);
      if (WrEn) begin
        rf[Address] = WrData;
        wr_cnt++;
      end
      if (rd_pend) begin
        RdData = rf[rd_addr];
        RdData_Valid = 1'b1;
        rd_pend = 1'b0;
      end
      if (RdEn) begin
        rd_pend = 1'b1;
        rd_addr = Address;
        rd_cnt++;
      end
      if (alu_pend) begin
        if (alu_left <= 0) begin
          ALU_OUT = alu_res;
          ALU_OUT_VLD = 1'b1;
          alu_pend = 1'b0;
        end else alu_left--;
      end
      if (ALU_EN) begin
        alu_cnt++;
        chk("gate_at_alu_en", 32'(CLK_GATE_EN), 32'd1);
        alu_res = alu_force ? alu_force_val : alu_fn(ALU_FUN, rf[0], rf[1]);
        alu_pend = 1'b1;
        alu_left = alu_lat - 1;
      end
      // UART: may stall before accepting, then stays busy a random while
      if (TX_D_VLD && !vld_prev) chk("tx_vld_while_busy", 32'(TX_Busy), 32'd0);
      if (holding) chk("tx_vld_held", 32'(TX_D_VLD), 32'd1);
      if (TX_Busy) begin
        busy_left--;
        if (busy_left <= 0) TX_Busy = 1'b0;
      end else if (TX_D_VLD) begin
        if (holding) chk("tx_data_held", 32'(TX_P_DATA), 32'(held));
        if (stall > 0) begin
          stall--;
          holding = 1'b1;
          held = TX_P_DATA;
        end else begin
          tx_q.push_back(TX_P_DATA);
          TX_Busy = 1'b1;
          busy_left = $urandom_range(1, 4);
          stall = $urandom_range(0, 2);
          holding = 1'b0;
        end
      end else holding = 1'b0;
      vld_prev = TX_D_VLD;
    end
  end

  // Drive one byte; one cycle later check which strobe (if any) it produced.
  // kind: 0 none, 1 write (addr,data), 2 read (addr), 3 ALU (addr = fun)
  task automatic put_byte(input logic [7:0] b, input int gap, input int kind,
                          input logic [7:0] addr, input logic [7:0] data);
    RX_P_DATA = b;
    RX_D_VLD  = 1'b1;
    @(negedge CLK);
    RX_D_VLD  = 1'b0;
    chk("WrEn", 32'(WrEn), 32'(kind == 1));
    chk("RdEn", 32'(RdEn), 32'(kind == 2));
    chk("ALU_EN", 32'(ALU_EN), 32'(kind == 3));
    if (kind == 1 || kind == 2) chk("Address", 32'(Address), 32'(addr[3:0]));
    if (kind == 1) chk("WrData", 32'(WrData), 32'(data));
    if (kind == 3) chk("ALU_FUN", 32'(ALU_FUN), 32'(addr[3:0]));
    repeat (gap) @(negedge CLK);
  endtask

  // Wait for the expected response bytes, then compare everything for the frame
  task automatic finish_frame();
    int n;
    int t;
    n = exp_tx_q.size();
    t = 0;
    while (!(tx_q.size() >= n && !TX_Busy && !TX_D_VLD) && t < 400) begin
      @(negedge CLK);
      t++;
    end
    chk("tx_timeout", 32'(t >= 400), 32'd0);
    repeat (3) @(negedge CLK);
    chk("tx_count", 32'(tx_q.size()), 32'(n));
    while (exp_tx_q.size() > 0) begin
      if (tx_q.size() > 0) chk("tx_byte", 32'(tx_q.pop_front()), 32'(exp_tx_q.pop_front()));
      else void'(exp_tx_q.pop_front());
    end
    tx_q.delete();
    chk("wr_count", 32'(wr_cnt), 32'(exp_wr));
    chk("rd_count", 32'(rd_cnt), 32'(exp_rd));
    chk("alu_count", 32'(alu_cnt), 32'(exp_alu));
    chk("gate_idle", 32'(CLK_GATE_EN), 32'd0);
    chk("tx_vld_idle", 32'(TX_D_VLD), 32'd0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_WrEn"}, 32'(WrEn), 32'd0);
    chk({tag, "_RdEn"}, 32'(RdEn), 32'd0);
    chk({tag, "_ALU_EN"}, 32'(ALU_EN), 32'd0);
    chk({tag, "_Address"}, 32'(Address), 32'd0);
    chk({tag, "_WrData"}, 32'(WrData), 32'd0);
    chk({tag, "_ALU_FUN"}, 32'(ALU_FUN), 32'd0);
    chk({tag, "_GATE"}, 32'(CLK_GATE_EN), 32'd0);
    chk({tag, "_TX_P_DATA"}, 32'(TX_P_DATA), 32'd0);
    chk({tag, "_TX_D_VLD"}, 32'(TX_D_VLD), 32'd0);
  endtask

  initial begin : stimulus
    logic [15:0] r;
    logic [7:0]  b0, b1, b2, b3, junk;
    int          c, g;
    logic        do_junk;
    RST = 1'b0;
    RX_P_DATA = 8'h0;
    RX_D_VLD = 1'b0;
    for (int i = 0; i < 16; i++) ref_regs[i] = 8'h0;
    repeat (3) @(negedge CLK);
    chk_all_zero("reset");
    RST = 1'b1;
    @(negedge CLK);

    // Write reg5 = 0x3C
    put_byte(8'hAA, 0, 0, 8'h0, 8'h0);
    put_byte(8'h05, 0, 0, 8'h0, 8'h0);
    put_byte(8'h3C, 0, 1, 8'h05, 8'h3C);
    ref_regs[5] = 8'h3C; exp_wr++;
    finish_frame();

    // Read reg5, expect 0x3C back
    put_byte(8'hBB, 0, 0, 8'h0, 8'h0);
    put_byte(8'h05, 0, 2, 8'h05, 8'h0);
    exp_rd++; exp_tx_q.push_back(8'h3C);
    finish_frame();

    // Full ALU frame: 10 * 3 = 0x001E
    put_byte(8'hCC, 0, 0, 8'h0, 8'h0);
    put_byte(8'h0A, 0, 1, 8'h00, 8'h0A);
    put_byte(8'h03, 1, 1, 8'h01, 8'h03);
    chk("gate_in_fun", 32'(CLK_GATE_EN), 32'd1);
    put_byte(8'h02, 0, 3, 8'h02, 8'h0);
    ref_regs[0] = 8'h0A; ref_regs[1] = 8'h03; exp_wr += 2; exp_alu++;
    exp_tx_q.push_back(8'h1E); exp_tx_q.push_back(8'h00);
    finish_frame();

    // ALU on current operands, forced result 0xABCD
    alu_force = 1'b1; alu_force_val = 16'hABCD;
    put_byte(8'hDD, 0, 0, 8'h0, 8'h0);
    chk("gate_in_fun_dd", 32'(CLK_GATE_EN), 32'd1);
    put_byte(8'h01, 0, 3, 8'h01, 8'h0);
    exp_alu++; exp_tx_q.push_back(8'hCD); exp_tx_q.push_back(8'hAB);
    finish_frame();
    alu_force = 1'b0;

    // Unknown command ignored, then a normal write
    put_byte(8'h55, 1, 0, 8'h0, 8'h0);
    put_byte(8'hAA, 0, 0, 8'h0, 8'h0);
    put_byte(8'h02, 0, 0, 8'h0, 8'h0);
    put_byte(8'h11, 0, 1, 8'h02, 8'h11);
    ref_regs[2] = 8'h11; exp_wr++;
    finish_frame();

    // Reset while waiting for the ALU; the late result must be ignored
    alu_lat = 12;
    put_byte(8'hDD, 0, 0, 8'h0, 8'h0);
    put_byte(8'h03, 0, 3, 8'h03, 8'h0);
    exp_alu++;
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    #1;
    chk_all_zero("abort");
    @(negedge CLK);
    @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    put_byte(8'hAA, 0, 0, 8'h0, 8'h0);
    put_byte(8'h01, 0, 0, 8'h0, 8'h0);
    put_byte(8'h77, 0, 1, 8'h01, 8'h77);
    ref_regs[1] = 8'h77; exp_wr++;
    repeat (15) @(negedge CLK);
    finish_frame();

    // Randomized frames, back-to-back bytes and dropped bytes mixed in
    for (int f = 0; f < 60; f++) begin
      c = $urandom_range(0, 4);
      b1 = 8'($urandom); b2 = 8'($urandom); b3 = 8'($urandom);
      junk = 8'($urandom);
      do_junk = ($urandom_range(0, 2) == 0);
      g = do_junk ? 0 : rgap();
      alu_lat = $urandom_range(1, 4);
      case (c)
        0: begin
          put_byte(8'hAA, rgap(), 0, 8'h0, 8'h0);
          put_byte(b1, rgap(), 0, 8'h0, 8'h0);
          put_byte(b2, rgap(), 1, b1, b2);
          ref_regs[b1[3:0]] = b2; exp_wr++;
        end
        1: begin
          put_byte(8'hBB, rgap(), 0, 8'h0, 8'h0);
          put_byte(b1, g, 2, b1, 8'h0);
          if (do_junk) put_byte(junk, 0, 0, 8'h0, 8'h0);
          exp_rd++; exp_tx_q.push_back(ref_regs[b1[3:0]]);
        end
        2: begin
          put_byte(8'hCC, rgap(), 0, 8'h0, 8'h0);
          put_byte(b1, rgap(), 1, 8'h00, b1);
          put_byte(b2, rgap(), 1, 8'h01, b2);
          chk("gate_in_fun_rand", 32'(CLK_GATE_EN), 32'd1);
          put_byte(b3, g, 3, b3, 8'h0);
          if (do_junk) put_byte(junk, 0, 0, 8'h0, 8'h0);
          ref_regs[0] = b1; ref_regs[1] = b2; exp_wr += 2; exp_alu++;
          r = alu_fn(b3[3:0], b1, b2);
          exp_tx_q.push_back(r[7:0]); exp_tx_q.push_back(r[15:8]);
        end
        3: begin
          put_byte(8'hDD, rgap(), 0, 8'h0, 8'h0);
          put_byte(b3, g, 3, b3, 8'h0);
          if (do_junk) put_byte(junk, 0, 0, 8'h0, 8'h0);
          exp_alu++;
          r = alu_fn(b3[3:0], ref_regs[0], ref_regs[1]);
          exp_tx_q.push_back(r[7:0]); exp_tx_q.push_back(r[15:8]);
        end
        default: begin
          b0 = 8'($urandom);
          while (b0 == 8'hAA || b0 == 8'hBB || b0 == 8'hCC || b0 == 8'hDD) b0 = 8'($urandom);
          put_byte(b0, rgap(), 0, 8'h0, 8'h0);
        end
      endcase
      finish_frame();
      repeat ($urandom_range(0, 3)) @(negedge CLK);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/sys_ctrl.md
# sys_ctrl

Command controller that is the initiator side of the register-file access interface. It parses byte frames arriving from the UART receiver and issues register-file writes and reads. It also launches ALU operations and returns read data or ALU results to the UART transmitter. It sits in the reference (fast) clock domain, between the RX/TX data synchronizers and the register file / ALU.

## Interface
- DATA_WIDTH, 8, width of UART bytes and register-file data
- ADDR_WIDTH, 4, register-file address width; address taken from byte bits [ADDR_WIDTH-1:0]
- FUN_WIDTH, 4, ALU function code width; taken from byte bits [FUN_WIDTH-1:0]
- ALU_WIDTH, 16, ALU result width (2*DATA_WIDTH)

Ports:
- CLK  in  1  clock
- RST  in  1  reset, asynchronous, active-low
- RX_P_DATA  in  DATA_WIDTH  received byte, valid when RX_D_VLD=1
- RX_D_VLD  in  1  one-cycle pulse per received byte
- RdData  in  DATA_WIDTH  register-file read data
- RdData_Valid  in  1  register-file read data valid, one cycle
- ALU_OUT  in  ALU_WIDTH  ALU result
- ALU_OUT_VLD  in  1  ALU result valid, one cycle
- TX_Busy  in  1  UART transmitter busy
- WrEn  out  1  register-file write strobe, one cycle
- RdEn  out  1  register-file read strobe, one cycle
- Address  out  ADDR_WIDTH  register-file address
- WrData  out  DATA_WIDTH  register-file write data
- ALU_EN  out  1  ALU start strobe, one cycle
- ALU_FUN  out  FUN_WIDTH  ALU function select
- CLK_GATE_EN  out  1  ALU clock-gate enable
- TX_P_DATA  out  DATA_WIDTH  byte to transmit
- TX_D_VLD  out  1  transmit request

## Operation
- Frames, first byte is the command:
  - 0xAA: addr, data → write data to reg[addr].
  - 0xBB: addr → read reg[addr]; transmit 1 byte.
  - 0xCC: A, B, fun → write A to reg0, write B to reg1, run ALU; transmit result LSB then MSB.
  - 0xDD: fun → run ALU on the current reg0/reg1; transmit LSB then MSB.
- Any other first byte is ignored; state stays IDLE.
- States: IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, OPA, OPB, FUN, ALU_WAIT, TX_LO, TX_HI.
  - IDLE, RX_D_VLD with a valid command: go to WR_ADDR (0xAA), RD_ADDR (0xBB), OPA (0xCC) or FUN (0xDD).
  - WR_ADDR, byte: latch Address, go to WR_DATA.
  - WR_DATA, byte: pulse WrEn with WrData=byte, go to IDLE.
  - RD_ADDR, byte: latch Address, pulse RdEn, go to RD_WAIT.
  - RD_WAIT, RdData_Valid: capture RdData into the TX buffer, go to TX_LO (single-byte mode).
  - OPA, byte: WrEn, Address=0, WrData=byte, go to OPB.
  - OPB, byte: WrEn, Address=1, go to FUN.
  - FUN, byte: ALU_FUN=byte[FUN_WIDTH-1:0], pulse ALU_EN, go to ALU_WAIT.
  - ALU_WAIT, ALU_OUT_VLD: capture ALU_OUT, go to TX_LO.
  - TX_LO: send byte 0. Then go to TX_HI for an ALU response, or IDLE for a read response.
  - TX_HI: send byte 1, then go to IDLE.
- TX handshake, per byte:
  - Wait until TX_Busy=0.
  - Drive TX_P_DATA and assert TX_D_VLD, holding both until TX_Busy is sampled 1.
  - Then drop TX_D_VLD and wait for TX_Busy=0 before the next byte or before returning to IDLE.
- CLK_GATE_EN is 1 from entering FUN until the ALU result is captured; otherwise 0.
- RX_D_VLD in RD_WAIT, ALU_WAIT, TX_LO or TX_HI is dropped; no queueing.
- WrEn and RdEn are never high in the same cycle.
- No timeout: RD_WAIT and ALU_WAIT hold until the valid strobe arrives.

## Timing
- All outputs are registered.
- Reset values: all strobes 0, Address 0, WrData 0, ALU_FUN 0, CLK_GATE_EN 0, TX_P_DATA 0, TX_D_VLD 0; state IDLE.
- RST low mid-frame or mid-transmit aborts immediately and returns to IDLE; the partial frame is discarded.
- Byte accepted at cycle N, with RX_D_VLD sampled high:
  - WrEn, RdEn or ALU_EN is high in cycle N+1 only.
  - Address, WrData and ALU_FUN are valid in the same cycle as their strobe and hold afterward.
- The register file returns RdData_Valid 1 cycle after RdEn; the captured byte appears on TX_P_DATA with TX_D_VLD no earlier than the following cycle.
- Back-to-back RX bytes in consecutive cycles are accepted.

## Test plan
- 0xAA,0x05,0x3C → one WrEn pulse with Address=5, WrData=0x3C; back to IDLE; no TX.
- 0xBB,0x05 with the model returning 0x3C → one RdEn pulse with Address=5; TX_P_DATA=0x3C sent once, TX_D_VLD held until TX_Busy rises.
- 0xCC,0x0A,0x03,0x02 with the ALU model returning 0x001E → writes reg0=0x0A and reg1=0x03; one ALU_EN pulse with ALU_FUN=2; CLK_GATE_EN high until the result is captured; TX sends 0x1E then 0x00.
- 0xDD,0x01 with the model returning 0xABCD → no WrEn; ALU_EN pulse with ALU_FUN=1; TX sends 0xCD, waits for TX_Busy low, then sends 0xAB.
- 0x55 followed by 0xAA,0x02,0x11 → 0x55 ignored; single write reg2=0x11.
- RST low during ALU_WAIT, then 0xAA,0x01,0x77 → all outputs 0, IDLE; the new frame writes normally; the stale ALU_OUT_VLD causes no TX.
